// File: rtl/board_ctrl_pkg.sv
// board_ctrl_pkg: shared timing constants, the per-button event record and
// a counter-width helper for the board control block.
package board_ctrl_pkg;

    localparam int FRAME_CYCLES         = 800 * 525;
    localparam int SECOND_CYCLES        = 60 * FRAME_CYCLES;
    localparam int POR_CYCLES_DEF       = 512;
    localparam int DEBOUNCE_CYCLES_DEF  = 65536;
    localparam int HOLD_CYCLES_DEF      = SECOND_CYCLES;
    localparam int HEARTBEAT_CYCLES_DEF = SECOND_CYCLES;

    // Debounced state of one button plus its one-cycle edge pulses.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } btn_evt_t;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and registered
// rise/fall pulses for a single pushbutton. flip_o is the combinational
// "level changes at this edge" strobe so the parent can act on the same
// edge the debounced level moves.
module btn_debounce
    import board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     raw_i,
    output btn_evt_t evt_o,
    output logic     flip_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    btn_evt_t      evt_q, evt_d;
    logic          flip;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (sync2_q != evt_q.level) begin
            if (cnt_q == CNT_LAST) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        evt_d.level = flip ? sync2_q : evt_q.level;
        evt_d.rise  = flip & sync2_q;
        evt_d.fall  = flip & ~sync2_q;
    end

    // Debounce counter and registered level/edge outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign evt_o  = evt_q;
    assign flip_o = flip;

endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: debounced buttons, power-up reset stretch, optional
// hold-to-reset on button RESET_BTN and a heartbeat square wave.
// Build option: define BOARD_CTRL_HOLD_RESET_EN to enable hold-to-reset;
// without it RESET_BTN is an ordinary button.
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int NUM_BTNS         = 4,
    parameter int RESET_BTN        = 0,
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int POR_CYCLES       = POR_CYCLES_DEF,
    parameter int HOLD_CYCLES      = HOLD_CYCLES_DEF,
    parameter int HEARTBEAT_CYCLES = HEARTBEAT_CYCLES_DEF
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_rise,
    output logic [NUM_BTNS-1:0] btn_fall,
    output logic                sys_reset,
    output logic                heartbeat
);

    if (RESET_BTN < 0 || RESET_BTN >= NUM_BTNS || DEBOUNCE_CYCLES < 1 ||
        POR_CYCLES < 1 || HEARTBEAT_CYCLES < 1) begin : g_bad_params
        $error("board_ctrl: parameter out of range");
    end

    // ---------------- buttons ----------------
    btn_evt_t [NUM_BTNS-1:0] evt;
    logic     [NUM_BTNS-1:0] btn_flip;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i (clk_pixel),
            .rst_i (reset),
            .raw_i (btn_raw[i]),
            .evt_o (evt[i]),
            .flip_o(btn_flip[i])
        );
        assign btn_level[i] = evt[i].level;
        assign btn_rise[i]  = evt[i].rise;
        assign btn_fall[i]  = evt[i].fall;
    end

    // Only the reset button's flip strobe feeds the hold logic.
    logic unused_flip;
    assign unused_flip = ^btn_flip;

    // ---------------- POR stretch ----------------
    localparam int            PW       = cnt_width(POR_CYCLES);
    localparam logic [PW-1:0] POR_LOAD = PW'(POR_CYCLES);

    logic [PW-1:0] por_cnt_q, por_cnt_d;
    logic          por_active;
    logic          por_reload;
    logic          hold_active;

    assign por_active = (por_cnt_q != '0);

    // Count down to zero and stay there; a hold release restarts the stretch.
    always_comb begin
        por_cnt_d = por_cnt_q;
        if (por_reload) begin
            por_cnt_d = POR_LOAD;
        end else if (por_active) begin
            por_cnt_d = por_cnt_q - 1'b1;
        end
    end

    // POR counter register; reset loads the full stretch.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            por_cnt_q <= POR_LOAD;
        end else begin
            por_cnt_q <= por_cnt_d;
        end
    end

    // ---------------- hold-to-reset ----------------
`ifdef BOARD_CTRL_HOLD_RESET_EN
    localparam int            HW       = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    assign hold_active = (hold_cnt_q == HOLD_MAX);
    // Release is taken from the debouncer's strobe so the stretch starts on
    // the very edge the debounced level drops.
    assign por_reload  = hold_active & btn_flip[RESET_BTN] & btn_level[RESET_BTN];

    // Saturating count of debounced-held cycles; any release clears it.
    always_comb begin
        hold_cnt_d = '0;
        if (btn_level[RESET_BTN]) begin
            hold_cnt_d = hold_active ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_active = 1'b0;
    assign por_reload  = 1'b0;
`endif

    // ---------------- system reset ----------------
    logic sys_reset_q;

    // Registered OR of all reset sources.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            sys_reset_q <= 1'b1;
        end else begin
            sys_reset_q <= por_active | hold_active;
        end
    end

    assign sys_reset = sys_reset_q;

    // ---------------- heartbeat ----------------
    localparam int            BW      = cnt_width(HEARTBEAT_CYCLES);
    localparam logic [BW-1:0] HB_LAST = BW'(HEARTBEAT_CYCLES - 1);

    logic [BW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_q, hb_d;

    // Wrap the half-period counter and toggle the LED on each wrap.
    always_comb begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        hb_d     = hb_q;
        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    // Heartbeat registers; only the board reset clears them, so the LED keeps
    // blinking through a hold-reset.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign heartbeat = hb_q;

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Board-level control block for the FPGA top: it turns raw pushbutton pins into clean, debounced button signals, generates the system reset and drives a heartbeat for a status LED. The system reset covers both power-up and a long hold on a designated reset button. It sits between the board pins and the console core's `rst_n`/`ui_in`, clocked by the PLL pixel clock. It generalises the fixed single-button hold/power-up logic to N buttons with parametrised timings.

## Interface
Parameters:
- `NUM_BTNS`, 4, number of button inputs
- `RESET_BTN`, 0, index of the button that triggers hold-to-reset
- `DEBOUNCE_CYCLES`, 65536, consecutive stable cycles required to accept a level change (≥1)
- `POR_CYCLES`, 512, reset-stretch length after `reset` deasserts or a hold-reset is released (≥1)
- `HOLD_CYCLES`, 25200000, debounced-hold length that triggers reset (1 s at 60 frames × 800×525)
- `HEARTBEAT_CYCLES`, 25200000, heartbeat half-period

Ports:
- `clk_pixel`  in  1  pixel clock
- `reset`  in  1  synchronous, active-high (e.g. PLL not locked)
- `btn_raw`  in  NUM_BTNS  asynchronous button pins, active-high (caller inverts active-low pins)
- `btn_level`  out  NUM_BTNS  debounced level
- `btn_rise`  out  NUM_BTNS  one-cycle pulse on debounced 0→1
- `btn_fall`  out  NUM_BTNS  one-cycle pulse on debounced 1→0
- `sys_reset`  out  1  active-high system reset
- `heartbeat`  out  1  square wave for LED

One clock; reset is synchronous and active-high.

## Operation
- Synchroniser: 2-flop chain per button; resets to 0.
- Debounce, per button:
  - Counter clears whenever the synchronised value equals `btn_level`.
  - Otherwise it increments; on the cycle the count would reach `DEBOUNCE_CYCLES`, `btn_level` flips, the matching rise/fall pulses, and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` produces no change.
- POR stretch:
  - `por_cnt` loads `POR_CYCLES` on `reset`, decrements to 0, holds at 0.
  - `por_active = (por_cnt != 0)`.
- Hold-to-reset:
  - `hold_cnt` increments, saturating at `HOLD_CYCLES`, while `btn_level[RESET_BTN]` is 1; clears when it is 0.
  - `hold_active = (hold_cnt == HOLD_CYCLES)`.
  - Falling edge of `btn_level[RESET_BTN]` while `hold_active` reloads `por_cnt` with `POR_CYCLES`.
- `sys_reset = reset | por_active | hold_active`, registered.
- Heartbeat:
  - Counter runs from 0 to `HEARTBEAT_CYCLES-1`, wraps, and toggles `heartbeat` on wrap.
  - Cleared only by `reset`, not by `sys_reset`, so it blinks during a hold-reset.
- Buttons are never masked by `sys_reset`; debouncing continues through system reset.
- Counter widths are `$clog2(param+1)`. All counters saturate or wrap explicitly; none overflows.

## Timing
- Reset values:
  - `btn_level`, `btn_rise`, `btn_fall`, `heartbeat` = 0.
  - `sys_reset` = 1.
  - `por_cnt` = `POR_CYCLES`; other counters = 0.
- Raw edge to `btn_level` change: 2 (sync) + `DEBOUNCE_CYCLES` cycles, input held stable throughout.
- `sys_reset` stays high for 1 + `POR_CYCLES` cycles after the first cycle with `reset` low.
- Hold: `sys_reset` rises 1 cycle after `hold_cnt` reaches `HOLD_CYCLES`. It stays high while held, then for `POR_CYCLES` cycles after the debounced release.
- `reset` asserted mid-hold or mid-debounce: all state returns to reset values the next cycle.
- Hold shorter than `HOLD_CYCLES`: no `sys_reset`. Re-press restarts the count from 0.
- Heartbeat period is 2×`HEARTBEAT_CYCLES` cycles.

## Configuration
- `BOARD_CTRL_HOLD_RESET_EN`:
  - Defined: hold-to-reset as described.
  - Undefined: `hold_cnt`/`hold_active` logic is removed, `sys_reset = reset | por_active`, and `RESET_BTN` is ignored; `RESET_BTN` behaves like an ordinary button.

## Structure
- Package `board_ctrl_pkg`:
  - `FRAME_CYCLES = 800*525`
  - `SECOND_CYCLES = 60*FRAME_CYCLES`
  - default `POR_CYCLES`
  - `DEBOUNCE_CYCLES` constants
- Sub-module `btn_debounce`: synchroniser, counter and edge pulses for one button. Instantiated `NUM_BTNS` times via generate.
- Top level owns POR, hold and heartbeat logic.

## Test plan
Bench parameters: NUM_BTNS=2, DEBOUNCE_CYCLES=4, POR_CYCLES=8, HOLD_CYCLES=20, HEARTBEAT_CYCLES=10.
- Assert `reset` 3 cycles then release -> `sys_reset` high through cycle 9 after release, low at cycle 10; heartbeat first toggles 10 cycles after release.
- `btn_raw[1]` 0→1 held -> `btn_level[1]` rises and `btn_rise[1]` pulses exactly once, 6 cycles later.
- `btn_raw[1]` 3-cycle glitch -> `btn_level[1]`, `btn_rise[1]`, `btn_fall[1]` stay 0.
- Hold `btn_raw[0]` 40 cycles, then release:
  - `sys_reset` rises 27 cycles after press and stays high through the debounced release.
  - It then stays high 8 more cycles and falls.
- Hold `btn_raw[0]` 15 debounced cycles then release -> no `sys_reset`.
- Assert `reset` mid-hold (cycle 20 of hold) -> `hold_cnt`, `btn_level` clear; `sys_reset` follows POR sequence only. With macro undefined, the 40-cycle hold produces no `sys_reset`.
